vid_pattern_gen: RTL and testbench
==================================

# vid_pattern_gen

Synthesizable raster video source producing ZX-style hsync/vsync and 2-bit-per-channel RGB test patterns. It is the transmitting end of the sync+RGB interface measured and displayed by the simulation pixel monitor. In hardware it serves as a fallback and bring-up video source, and in simulation as a known-good stimulus for the monitor. All timing is parameterized, and outputs are registered.

## Interface
- HTOTAL, 448: pixel clocks per line
- HSYNC_LEN, 32: hsync pulse width in pixel clocks
- HACT_BEG, 80: first active pixel column
- HACT_LEN, 256: active width; power of two, ≥ 8
- VTOTAL, 320: lines per frame
- VSYNC_LEN, 2: vsync pulse width in lines
- VACT_BEG, 64: first active line
- VACT_LEN, 192: active height

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  advance raster; 0 freezes counters and all outputs
- pat_sel  in  2  pattern select; sampled once per frame
- border  in  6  border colour {r[1:0],g[1:0],b[1:0]}
- hsync  out  1  active-high line sync
- vsync  out  1  active-high frame sync
- red  out  2  red level
- grn  out  2  green level
- blu  out  2  blue level
- frame_start  out  1  one-cycle strobe aligned with the first pixel of a frame
- frame_cnt  out  8  frame counter, wraps

## Operation
- Counters: hcnt runs 0..HTOTAL-1. On wrap, vcnt advances 0..VTOTAL-1. Counters advance only when en=1.
- Registered outputs: on each clock edge with en=1, every output is loaded from f(hcnt,vcnt,pat,frame_cnt), and the counters step. Outputs therefore lag their position by one cycle.
- Sync:
  - hsync = (hcnt < HSYNC_LEN)
  - vsync = (vcnt < VSYNC_LEN)
  - Both are full-line aligned. vsync changes only when hcnt=0.
- Region priority, highest first:
  - blank: hsync or vsync region → rgb = 0
  - active: HACT_BEG ≤ hcnt < HACT_BEG+HACT_LEN and VACT_BEG ≤ vcnt < VACT_BEG+VACT_LEN
  - border: everything else → rgb = border
- Active coordinates: x = hcnt−HACT_BEG, y = vcnt−VACT_BEG. Both are unsigned and width-sized to their ranges.
- Patterns, selected by the latched value pat:
  - 0 (solid): rgb = 2'b10 on each channel (grey-white)
  - 1 (bars): idx = x >> (log2(HACT_LEN)−3), giving 8 equal bars. b = idx[0], r = idx[1], g = idx[2]. A set channel outputs 2'b10, a clear one 2'b00. Order is black, blue, red, magenta, green, cyan, yellow, white.
  - 2 (checker): c = x[3]^y[3]^frame_cnt[4]. c=1 → all channels 2'b11, else 0. The phase inverts every 16 frames.
  - 3 (ramp): red = x[7:6], grn = y[7:6], blu = frame_cnt[1:0]
- pat is loaded from pat_sel on the edge where (hcnt,vcnt) = (HTOTAL−1,VTOTAL−1) with en=1. A change of pat_sel mid-frame therefore takes effect from the next frame's first pixel. Reset value of pat is 0.
- frame_cnt increments on the same edge that loads pat. 8'hFF wraps to 8'h00.
- frame_start = 1 on the edge that loads position (0,0) into the outputs, and 0 otherwise.

## Timing
- Reset (rst_n=0, asynchronous):
  - hcnt=0, vcnt=0, pat=0, frame_cnt=0
  - hsync=0, vsync=0, red=grn=blu=0, frame_start=0
- First en=1 edge after reset release: outputs reflect position (0,0), so hsync=1, vsync=1, frame_start=1, rgb=0. frame_cnt stays 0.
- hsync rising-edge period is exactly HTOTAL cycles; high for HSYNC_LEN cycles.
- vsync rising-edge period is exactly HTOTAL·VTOTAL cycles; high for VSYNC_LEN·HTOTAL cycles. Its rising edge coincides with an hsync rising edge.
- en=0: every register, including frame_start, holds its value. If frame_start was high, it stays high until en returns; the next enabled edge drops it. The raster resumes with no skipped or repeated positions.
- Reset asserted mid-frame: all state clears immediately. The raster restarts at (0,0) on the first enabled edge after release.
- Parameters are elaboration-time legal only if:
  - HSYNC_LEN < HACT_BEG
  - HACT_BEG+HACT_LEN ≤ HTOTAL
  - VSYNC_LEN < VACT_BEG
  - VACT_BEG+VACT_LEN ≤ VTOTAL
  - Violations are a compile-time error.

## Test plan
- Reset, en=1, defaults → hsync rises every 448 cycles, high for 32; vsync rises every 143360 cycles, high for 896; frame_start one cycle per frame.
- pat_sel=1 → on line 64, pixels at x=0, 32, …, 224 give {r,g,b} = 000000, 000010, 100000, 100010, 001000, 001010, 101000, 101010; border pixels equal the border input; hsync region gives 0.
- pat_sel changed 0→2 at mid-frame → current frame stays solid 2'b10; next frame has an 8×8 checker with (x=0,y=0) = 0 and (x=8,y=0) = 6'h3F; after 16 further frames the checker phase is inverted.
- en toggled 0 for 100 cycles at random points, including on the frame_start cycle → outputs frozen throughout; the measured periods, excluding frozen cycles, are unchanged.
- Run 256 frames → frame_cnt goes 8'hFF → 8'h00 on the last-pixel edge; pat=3 gives blu = frame_cnt[1:0] in the active area.
- rst_n pulsed low asynchronously (between clock edges) mid-line → outputs are 0 within the same cycle; after release, the first enabled edge gives hsync=vsync=frame_start=1.

Source files
------------

// File: rtl/vid_pattern_gen.sv
// Raster video source: ZX-style hsync/vsync plus 2-bit RGB test patterns.
// Every output is registered, so it lags the raster position by one clock.
module vid_pattern_gen #(
    parameter int HTOTAL    = 448,
    parameter int HSYNC_LEN = 32,
    parameter int HACT_BEG  = 80,
    parameter int HACT_LEN  = 256,
    parameter int VTOTAL    = 320,
    parameter int VSYNC_LEN = 2,
    parameter int VACT_BEG  = 64,
    parameter int VACT_LEN  = 192
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] pat_sel,
    input  logic [5:0] border,
    output logic       hsync,
    output logic       vsync,
    output logic [1:0] red,
    output logic [1:0] grn,
    output logic [1:0] blu,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int HW = $clog2(HTOTAL);
    localparam int VW = $clog2(VTOTAL);
    localparam int XW = $clog2(HACT_LEN);

    localparam logic [31:0] HS_END = 32'(HSYNC_LEN);
    localparam logic [31:0] VS_END = 32'(VSYNC_LEN);
    localparam logic [31:0] HA_BEG = 32'(HACT_BEG);
    localparam logic [31:0] HA_END = 32'(HACT_BEG + HACT_LEN);
    localparam logic [31:0] VA_BEG = 32'(VACT_BEG);
    localparam logic [31:0] VA_END = 32'(VACT_BEG + VACT_LEN);

    if (HSYNC_LEN >= HACT_BEG || HACT_BEG + HACT_LEN > HTOTAL) begin : g_bad_h
        $error("vid_pattern_gen: illegal horizontal timing");
    end
    if (VSYNC_LEN >= VACT_BEG || VACT_BEG + VACT_LEN > VTOTAL) begin : g_bad_v
        $error("vid_pattern_gen: illegal vertical timing");
    end
    if (HACT_LEN < 8 || (HACT_LEN & (HACT_LEN - 1)) != 0) begin : g_bad_w
        $error("vid_pattern_gen: HACT_LEN must be a power of two >= 8");
    end

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [1:0]    pat;

    logic        h_last;
    logic        v_last;
    logic [31:0] h32;
    logic [31:0] v32;
    logic [31:0] x;
    logic [31:0] y;
    logic        hs_nxt;
    logic        vs_nxt;
    logic        act;
    logic [2:0]  idx;
    logic        cb;
    logic [5:0]  pix;
    logic [5:0]  rgb;
    logic        unused;

    assign h_last = (hcnt == HW'(HTOTAL - 1));
    assign v_last = (vcnt == VW'(VTOTAL - 1));

    assign h32 = 32'(hcnt);
    assign v32 = 32'(vcnt);

    assign hs_nxt = (h32 < HS_END);
    assign vs_nxt = (v32 < VS_END);
    assign act    = (h32 >= HA_BEG) && (h32 < HA_END)
                 && (v32 >= VA_BEG) && (v32 < VA_END);

    // Coordinates are only meaningful inside the active window.
    assign x = h32 - HA_BEG;
    assign y = v32 - VA_BEG;

    assign idx    = 3'(x >> (XW - 3));
    assign cb     = x[3] ^ y[3] ^ frame_cnt[4];
    assign unused = ^{x, y};

    always_comb begin
        pix = '0;
        unique case (pat)
            2'd0:    pix = 6'b10_10_10;
            2'd1:    pix = {idx[1], 1'b0, idx[2], 1'b0, idx[0], 1'b0};
            2'd2:    pix = {6{cb}};
            default: pix = {x[7:6], y[7:6], frame_cnt[1:0]};
        endcase
    end

    always_comb begin
        rgb = border;
        if (hs_nxt || vs_nxt) begin
            rgb = '0;
        end else if (act) begin
            rgb = pix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt        <= '0;
            vcnt        <= '0;
            pat         <= '0;
            frame_cnt   <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            red         <= '0;
            grn         <= '0;
            blu         <= '0;
            frame_start <= 1'b0;
        end else if (en) begin
            hcnt <= h_last ? '0 : hcnt + HW'(1);
            if (h_last) begin
                vcnt <= v_last ? '0 : vcnt + VW'(1);
            end
            // Pattern changes only at the frame boundary.
            if (h_last && v_last) begin
                pat       <= pat_sel;
                frame_cnt <= frame_cnt + 8'd1;
            end
            hsync             <= hs_nxt;
            vsync             <= vs_nxt;
            {red, grn, blu}   <= rgb;
            frame_start       <= (hcnt == '0) && (vcnt == '0);
        end
    end

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Scoreboard bench for vid_pattern_gen on a small raster (20x10 clocks).
// Directed positions are checked against hand-computed outputs.
module tb_vid_pattern_gen;

    localparam int H  = 20;
    localparam int HS = 2;
    localparam int HB = 3;
    localparam int HL = 16;
    localparam int V  = 10;
    localparam int VS = 1;
    localparam int VB = 2;
    localparam int VL = 8;

    localparam logic [5:0] BRD = 6'h19;
    localparam logic [5:0] WHT = 6'b10_10_10;
    localparam logic [5:0] ALL = 6'h3F;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] pat_sel;
    logic [5:0] border;
    logic       hsync;
    logic       vsync;
    logic [1:0] red;
    logic [1:0] grn;
    logic [1:0] blu;
    logic       frame_start;
    logic [7:0] frame_cnt;

    vid_pattern_gen #(
        .HTOTAL(H), .HSYNC_LEN(HS), .HACT_BEG(HB), .HACT_LEN(HL),
        .VTOTAL(V), .VSYNC_LEN(VS), .VACT_BEG(VB), .VACT_LEN(VL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .pat_sel(pat_sel),
        .border(border),
        .hsync(hsync),
        .vsync(vsync),
        .red(red),
        .grn(grn),
        .blu(blu),
        .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [16:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   nxt = 0;
    int   ecnt = 0;

    logic [5:0] bars [8] = '{
        6'b00_00_00, 6'b00_00_10, 6'b10_00_00, 6'b10_00_10,
        6'b00_10_00, 6'b00_10_10, 6'b10_10_00, 6'b10_10_10
    };

    logic [16:0] act;
    assign act = {hsync, vsync, frame_start, red, grn, blu, frame_cnt};

    function automatic logic [16:0] e(logic hs, logic vs, logic fs,
                                      logic [5:0] rgb, logic [7:0] fc);
        return {hs, vs, fs, rgb, fc};
    endfunction

    task automatic chk(string n, logic [16:0] v);
        exp_t t;
        t.name = n;
        t.v    = v;
        q.push_back(t);
    endtask

    task automatic pcheck(string n, int got, int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s got %0d want %0d", n, got, want);
    endtask

    // Scoreboard monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t t;
        if (q.size() > 0) begin
            t = q.pop_front();
            checks++;
            if (act === t.v) passes++;
            else $display("FAIL %s got hs/vs/fs/rgb/fc=%b_%b_%b_%b_%h want %b_%b_%b_%b_%h",
                          t.name, act[16], act[15], act[14], act[13:8], act[7:0],
                          t.v[16], t.v[15], t.v[14], t.v[13:8], t.v[7:0]);
        end
    end

    // Enabled-edge counter; frozen cycles do not count toward periods.
    always @(posedge clk) begin
        if (rst_n && en) ecnt++;
    end

    int hr = 0;
    int vr = 0;
    bit hv = 0;
    bit vv = 0;
    bit phs = 0;
    bit pvs = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hv = 0; vv = 0; phs = 0; pvs = 0;
        end else begin
            if (hsync && !phs) begin
                if (hv) pcheck("hsync_period", ecnt - hr, H);
                hr = ecnt;
                hv = 1;
            end
            if (!hsync && phs && hv) pcheck("hsync_width", ecnt - hr, HS);
            if (vsync && !pvs) begin
                if (vv) pcheck("vsync_period", ecnt - vr, H * V);
                if (hsync !== 1'b1) pcheck("vsync_on_hsync", 0, 1);
                vr = ecnt;
                vv = 1;
            end
            if (!vsync && pvs && vv) pcheck("vsync_width", ecnt - vr, VS * H);
            phs = hsync;
            pvs = vsync;
        end
    end

    task automatic step();
        en = 1'b1;
        @(posedge clk);
        #1;
        nxt++;
    endtask

    task automatic run_to(int k);
        while (nxt <= k) step();
    endtask

    task automatic hold(int n, string name, logic [16:0] v);
        en = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk(name, v);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        pat_sel = 2'd0;
        border  = BRD;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", e(0, 0, 0, 6'h00, 8'h00));
        @(negedge clk);
        #1 rst_n = 1'b1;

        run_to(0);  chk("first_px",   e(1, 1, 1, 6'h00, 8'h00));
        run_to(1);  chk("px1",        e(1, 1, 0, 6'h00, 8'h00));
        run_to(2);  chk("vblank",     e(0, 1, 0, 6'h00, 8'h00));
        run_to(20); chk("line1_hs",   e(1, 0, 0, 6'h00, 8'h00));
        run_to(22); chk("border_top", e(0, 0, 0, BRD, 8'h00));
        run_to(30); pat_sel = 2'd1;
        run_to(45);  chk("solid",        e(0, 0, 0, WHT, 8'h00));
        run_to(199); chk("last_px",      e(0, 0, 0, BRD, 8'h01));
        run_to(200); chk("frame1_start", e(1, 1, 1, 6'h00, 8'h01));
        run_to(240); chk("hs_blank",     e(1, 0, 0, 6'h00, 8'h01));
        for (int i = 0; i < 8; i++) begin
            run_to(243 + 2 * i);
            chk($sformatf("bar%0d", i), e(0, 0, 0, bars[i], 8'h01));
        end
        run_to(259); chk("border_right", e(0, 0, 0, BRD, 8'h01));
        run_to(300); pat_sel = 2'd2;
        run_to(313); chk("bars_hold", e(0, 0, 0, 6'b00_10_10, 8'h01));
        run_to(443); chk("chk_x0",    e(0, 0, 0, 6'h00, 8'h02));
        run_to(451); chk("chk_x8",    e(0, 0, 0, ALL, 8'h02));

        run_to(600); chk("fs_pre_hold", e(1, 1, 1, 6'h00, 8'h03));
        hold(5, "fs_hold", e(1, 1, 1, 6'h00, 8'h03));
        run_to(601); chk("fs_drop", e(1, 1, 0, 6'h00, 8'h03));
        run_to(655); chk("pre_hold", e(0, 0, 0, ALL, 8'h03));
        hold(100, "mid_hold", e(0, 0, 0, ALL, 8'h03));
        run_to(656); chk("resume",        e(0, 0, 0, ALL, 8'h03));
        run_to(659); chk("resume_border", e(0, 0, 0, BRD, 8'h03));

        run_to(3643); chk("inv_x0", e(0, 0, 0, ALL, 8'h12));
        run_to(3651); chk("inv_x8", e(0, 0, 0, 6'h00, 8'h12));
        run_to(3700); pat_sel = 2'd3;
        run_to(3711); chk("chk_hold", e(0, 0, 0, 6'h00, 8'h12));
        run_to(3908); chk("ramp19",   e(0, 0, 0, 6'h03, 8'h13));
        run_to(4508); chk("ramp22",   e(0, 0, 0, 6'h02, 8'h16));

        run_to(51108); chk("ramp255",  e(0, 0, 0, 6'h03, 8'hFF));
        run_to(51198); chk("pre_wrap", e(0, 0, 0, 6'h03, 8'hFF));
        run_to(51199); chk("wrap",     e(0, 0, 0, BRD, 8'h00));
        run_to(51200); chk("wrap_fs",  e(1, 1, 1, 6'h00, 8'h00));

        run_to(51205);
        #2 rst_n = 1'b0;
        chk("async_rst", e(0, 0, 0, 6'h00, 8'h00));
        #10 rst_n = 1'b1;
        nxt = 0;
        run_to(0); chk("post_rst",  e(1, 1, 1, 6'h00, 8'h00));
        run_to(1); chk("post_rst1", e(1, 1, 0, 6'h00, 8'h00));

        repeat (2) @(negedge clk);
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL drain left %0d want 0", q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
